// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants.
package riscv_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    // One instruction-buffer entry: fetched word plus the PC it came from.
    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer between fetch and decode; flush clears it in one edge.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned PW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  fetch_entry_t  din,
    output fetch_entry_t  dout,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign count   = count_q;
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign dout    = mem_q[head_q];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Next pointers, occupancy and storage; clear overrides any push/pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[tail_q] = din;
                tail_d = (tail_q == PW'(DEPTH - 1)) ? '0 : tail_q + PW'(1);
            end
            if (pop_ok) begin
                head_d = (head_q == PW'(DEPTH - 1)) ? '0 : head_q + PW'(1);
            end
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC generation, one-deep request tracking, buffer to decode.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            id_valid,
    output logic [ILEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = CW + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tag_pc_q, tag_pc_d;
    logic            inflight_q, inflight_d;

    fetch_entry_t    fifo_din;
    fetch_entry_t    fifo_dout;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full;
    logic            fifo_push;
    logic            pop;
    logic            issue;
    logic [OW-1:0]   occ;

    // Buffered plus in-flight entries must never exceed the buffer size.
    assign occ       = OW'(fifo_count) + OW'(inflight_q);
    assign id_valid  = reset & ~fifo_empty;
    assign pop       = id_valid & ~stall;
    assign issue     = reset & ~flush & (((occ < OW'(DEPTH)) & ~fifo_full) | pop);
    assign imem_req  = issue;
    assign imem_addr = pc_q;
    assign fifo_push = inflight_q & ~flush;
    assign fifo_din  = '{instr: imem_rdata, pc: tag_pc_q};
    assign id_instr  = id_valid ? fifo_dout.instr : NOP_INSTR;
    assign id_pc     = id_valid ? fifo_dout.pc : '0;

    // PC and request-tag next state; a redirect discards the in-flight response.
    always_comb begin
        pc_d       = pc_q;
        tag_pc_d   = tag_pc_q;
        inflight_d = issue;
        if (flush) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d     = pc_q + 64'd4;
            tag_pc_d = pc_q;
        end
    end

    // Fetch control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            tag_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            tag_pc_q   <= tag_pc_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (pop),
        .clear (flush),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a random run against a queue model.
module tb_fetch_stage;

    localparam int unsigned DEPTH    = 3;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [63:0] id_pc;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: word(addr) = addr, one cycle after the request; junk otherwise.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? imem_addr[31:0] : $urandom;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset two edges, then leave the bench in the first cycle with reset==1.
    task automatic release_reset();
        reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            stall = 1'b1;
            @(negedge clk);
            n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", imem_req); end
            n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
            n_tests++; if (id_instr !== NOP) begin n_fail++; $display("FAIL reset_instr got=%h exp=%h", id_instr, NOP); end
            n_tests++; if (id_pc !== 64'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", id_pc); end
        end
        stall = 1'b0;
    endtask

    task automatic test_stream();
        release_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_tests++; if (imem_req !== 1'b1 || imem_addr !== 64'(4 * i)) begin
                n_fail++; $display("FAIL stream_addr c%0d got=%b/%h exp=1/%h", i, imem_req, imem_addr, 64'(4 * i)); end
            n_tests++; if (id_valid !== (i >= 2)) begin
                n_fail++; $display("FAIL stream_valid c%0d got=%b exp=%b", i, id_valid, (i >= 2)); end
            if (i >= 2) begin
                n_tests++; if (id_pc !== 64'(4 * (i - 2)) || id_instr !== 32'(4 * (i - 2))) begin
                    n_fail++; $display("FAIL stream_id c%0d got=%h/%h exp=%h", i, id_pc, id_instr, 64'(4 * (i - 2))); end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        release_reset();
        for (int i = 0; i < 4; i++) tick();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++; if (id_valid !== 1'b1 || id_pc !== 64'h8) begin
                n_fail++; $display("FAIL stall_hold s%0d got=%b/%h exp=1/8", i, id_valid, id_pc); end
            if (i >= 1) begin
                n_tests++; if (imem_req !== 1'b0) begin
                    n_fail++; $display("FAIL stall_req s%0d got=%b exp=0", i, imem_req); end
            end
            tick();
        end
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++; if (id_valid !== 1'b1 || id_pc !== 64'(8 + 4 * i)) begin
                n_fail++; $display("FAIL stall_resume r%0d got=%b/%h exp=1/%h", i, id_valid, id_pc, 64'(8 + 4 * i)); end
            tick();
        end
    endtask

    task automatic test_flush();
        release_reset();
        for (int i = 0; i < 4; i++) tick();
        stall = 1'b1;
        tick();
        stall = 1'b0; flush = 1'b1; redirect_pc = 64'h100;
        @(negedge clk);
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL flush_req got=%b exp=0", imem_req); end
        tick();
        flush = 1'b0;
        @(negedge clk);
        n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_cleared got=%b exp=0", id_valid); end
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 64'h100) begin
            n_fail++; $display("FAIL flush_addr got=%b/%h exp=1/100", imem_req, imem_addr); end
        tick();
        @(negedge clk);
        n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale got=%b exp=0", id_valid); end
        tick();
        @(negedge clk);
        n_tests++; if (id_valid !== 1'b1 || id_pc !== 64'h100 || id_instr !== 32'h100) begin
            n_fail++; $display("FAIL flush_first got=%b/%h/%h exp=1/100/100", id_valid, id_pc, id_instr); end
    endtask

    task automatic test_flush_stall();
        release_reset();
        for (int i = 0; i < 4; i++) tick();
        flush = 1'b1; stall = 1'b1; redirect_pc = 64'h40;
        tick();
        flush = 1'b0; stall = 1'b0;
        @(negedge clk);
        n_tests++; if (id_valid !== 1'b0 || imem_addr !== 64'h40) begin
            n_fail++; $display("FAIL fstall_clear got=%b/%h exp=0/40", id_valid, imem_addr); end
        tick();
        tick();
        @(negedge clk);
        n_tests++; if (id_valid !== 1'b1 || id_pc !== 64'h40) begin
            n_fail++; $display("FAIL fstall_first got=%b/%h exp=1/40", id_valid, id_pc); end
    endtask

    task automatic test_reset_mid();
        release_reset();
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b0;
        @(negedge clk);
        n_tests++; if (imem_req !== 1'b0 || id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 64'h0) begin
            n_fail++; $display("FAIL rstmid_out got=%b/%b/%h/%h exp=0/0/%h/0", imem_req, id_valid, id_instr, id_pc, NOP); end
        tick();
        reset = 1'b1;
        @(negedge clk);
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC || id_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_restart got=%b/%h/%b exp=1/%h/0", imem_req, imem_addr, id_valid, RESET_PC); end
        tick();
        @(negedge clk);
        n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale got=%b/%h exp=0", id_valid, id_pc); end
        tick();
        @(negedge clk);
        n_tests++; if (id_valid !== 1'b1 || id_pc !== RESET_PC) begin
            n_fail++; $display("FAIL rstmid_first got=%b/%h exp=1/%h", id_valid, id_pc, RESET_PC); end
    endtask

    task automatic test_wrap();
        release_reset();
        flush = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        flush = 1'b0;
        @(negedge clk);
        n_tests++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_first got=%h exp=fffffffffffffffc", imem_addr); end
        tick();
        @(negedge clk);
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
            n_fail++; $display("FAIL wrap_next got=%b/%h exp=1/0", imem_req, imem_addr); end
        tick();
        @(negedge clk);
        n_tests++; if (id_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_id0 got=%h exp=fffffffffffffffc", id_pc); end
        tick();
        @(negedge clk);
        n_tests++; if (id_valid !== 1'b1 || id_pc !== 64'h0) begin
            n_fail++; $display("FAIL wrap_id1 got=%b/%h exp=1/0", id_valid, id_pc); end
    endtask

    // Model: list of issued-but-not-consumed PCs with their issue cycle.
    task automatic test_random(input int ncyc);
        logic [63:0] q_pc[$];
        int          q_cyc[$];
        logic [63:0] next_pc;
        logic [63:0] head_pc;
        logic [63:0] rv;
        logic        exp_valid, exp_pop, exp_req;
        next_pc = RESET_PC;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            reset = (cyc < 2) ? 1'b0 : (($urandom % 100) >= 2);
            stall = (($urandom % 100) < 30);
            flush = (($urandom % 100) < 5);
            rv = {$urandom, $urandom};
            case ($urandom % 4)
                0:       rv = 64'hFFFF_FFFF_FFFF_FFF8;
                1:       rv[1:0] = 2'b10;
                default: rv[1:0] = 2'b00;
            endcase
            redirect_pc = rv;
            exp_valid = reset && q_pc.size() > 0 && (cyc - q_cyc[0] >= 2);
            exp_pop   = exp_valid && !stall;
            exp_req   = reset && !flush && (q_pc.size() < int'(DEPTH) || exp_pop);
            head_pc   = (q_pc.size() > 0) ? q_pc[0] : 64'h0;
            @(negedge clk);
            n_tests++; if (id_valid !== exp_valid) begin
                n_fail++; $display("FAIL rnd_valid c%0d got=%b exp=%b", cyc, id_valid, exp_valid); end
            n_tests++; if (imem_req !== exp_req) begin
                n_fail++; $display("FAIL rnd_req c%0d got=%b exp=%b", cyc, imem_req, exp_req); end
            if (exp_valid) begin
                n_tests++; if (id_pc !== head_pc || id_instr !== head_pc[31:0]) begin
                    n_fail++; $display("FAIL rnd_id c%0d got=%h/%h exp=%h", cyc, id_pc, id_instr, head_pc); end
            end else begin
                n_tests++; if (id_instr !== NOP) begin
                    n_fail++; $display("FAIL rnd_nop c%0d got=%h exp=%h", cyc, id_instr, NOP); end
            end
            if (exp_req) begin
                n_tests++; if (imem_addr !== next_pc) begin
                    n_fail++; $display("FAIL rnd_addr c%0d got=%h exp=%h", cyc, imem_addr, next_pc); end
            end
            if (!reset) begin
                q_pc.delete(); q_cyc.delete(); next_pc = RESET_PC;
            end else if (flush) begin
                q_pc.delete(); q_cyc.delete(); next_pc = redirect_pc;
            end else begin
                if (exp_pop) begin
                    void'(q_pc.pop_front());
                    void'(q_cyc.pop_front());
                end
                if (exp_req) begin
                    q_pc.push_back(next_pc);
                    q_cyc.push_back(cyc);
                    next_pc = next_pc + 64'd4;
                end
            end
            tick();
        end
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = '0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_flush_stall();
        test_reset_mid();
        test_wrap();
        test_random(3000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0, is the first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, is the number of instruction-buffer entries; legal values are 2 to 4.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-low; reset is asserted when reset==0, sampled on the clk rising edge.
REQ-005 Port stall, input, 1 bit: hazard hold from decode; the buffer head is not consumed.
REQ-006 Port flush, input, 1 bit: control-flow redirect from execute.
REQ-007 Port redirect_pc, input, 64 bits: target address, valid when flush==1.
REQ-008 Port imem_req, output, 1 bit: instruction-memory read strobe.
REQ-009 Port imem_addr, output, 64 bits: read address, equal to the current PC.
REQ-010 Port imem_rdata, input, 32 bits: instruction word, valid exactly 1 cycle after imem_req.
REQ-011 Port id_valid, output, 1 bit: the buffer head holds a live instruction.
REQ-012 Port id_instr, output, 32 bits: head instruction; 32'h00000013 (NOP) when id_valid==0.
REQ-013 Port id_pc, output, 64 bits: PC of the head instruction.

Function
REQ-014 Issue: imem_req=1 when flush==0 and (count+inflight<DEPTH or pop); imem_addr=pc; pc advances by 4 on each issue (64-bit wrap).
REQ-015 Pop: pop = id_valid and not stall; the head leaves the buffer on that edge.
REQ-016 Inflight: a 1-bit register plus a 64-bit tag_pc register record an issued request; they are set on issue and cleared otherwise.
REQ-017 Capture: when inflight==1 and no flush, {imem_rdata, tag_pc} is written to the buffer tail on the next edge.
REQ-018 Latency: a request issued in cycle N makes id_valid=1 in cycle N+2.
REQ-019 Throughput: with stall==0, sustain 1 instruction per cycle.
REQ-020 Ordering: instructions leave in strict PC order; the buffer never overflows and never drops an instruction.
REQ-021 Full buffer: when count==DEPTH, no issue occurs unless a pop happens in the same cycle.
REQ-022 Empty buffer: id_valid=0; stall has no effect.
REQ-023 Push and pop together: count is unchanged and the head advances.
REQ-024 Flush:
- In the flush cycle, imem_req=0.
- On the edge: pc<=redirect_pc, buffer cleared, inflight cleared, and the response in flight is discarded.
- First redirect request is issued the cycle after the flush cycle.
REQ-025 Flush with stall: flush has priority and the buffer is cleared anyway.
REQ-026 Back-to-back flush: the last flush's redirect_pc wins; no intermediate fetch is issued.
REQ-027 Misaligned redirect_pc is used as given; no alignment check is performed.

Reset
REQ-028 While reset==0 on an edge:
- pc<=RESET_PC.
- Buffer count, head and tail <=0.
- inflight<=0.
REQ-029 Outputs during reset: imem_req=0, id_valid=0, id_instr=NOP, id_pc=0.
REQ-030 Reset mid-operation discards all buffered and in-flight instructions; the response arriving after reset is ignored.
REQ-031 The first request is issued in the first cycle with reset==1, with imem_addr=RESET_PC.

Structure
REQ-032 Shared package riscv_pkg holds:
- XLEN=64 and ILEN=32.
- NOP_INSTR=32'h00000013.
- A packed struct fetch_entry_t of {instr[31:0], pc[63:0]}.
REQ-033 The buffer is one sub-module, fetch_fifo, parameterised by DEPTH. Its ports are push, pop, clear, din, dout, count, empty and full; its reset is synchronous and active-low.
REQ-034 The PC, inflight and issue logic stays in fetch_stage; decode and hazard logic stay outside this block.

Verification
REQ-035 Scenario: release reset with RESET_PC=0 and memory holding word(addr)=addr, stall=0 -> imem_addr 0,4,8,... one per cycle; id_valid rises 2 cycles after release; id_pc 0,4,8 on consecutive cycles.
REQ-036 Scenario: stall held 5 cycles at id_pc=8 -> id_pc stays 8; at most DEPTH entries are buffered; imem_req drops; after release 8,12,16 appear with none missing or duplicated.
REQ-037 Scenario: flush with redirect_pc=64'h100 while 2 entries are buffered and 1 is in flight -> next cycle id_valid=0; next imem_addr=64'h100; id_pc=64'h100 two cycles after the first redirect request.
REQ-038 Scenario: flush=1 and stall=1 in the same cycle with redirect_pc=64'h40 -> buffer cleared; the next valid id_pc is 64'h40.
REQ-039 Scenario: reset driven to 0 for 1 cycle in mid-stream -> id_valid=0 and imem_req=0 that cycle; fetch restarts at RESET_PC; the stale response is never presented.
REQ-040 Scenario: redirect_pc=64'hFFFF_FFFF_FFFF_FFFC -> the next imem_addr after it wraps to 64'h0.
